// File: rtl/fe_fetch_ctrl.sv
// Fetch-stage sequencing controller: arbitrates branch redirect, I-cache miss
// refill and decode stall into the fetch control code, and runs the refill handshake.
module fe_fetch_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fe_pc,
    input  logic              ic_miss,
    input  logic              id_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_done,
    output logic [1:0]        ctr,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam logic [1:0] CTR_ADV   = 2'b00;
    localparam logic [1:0] CTR_HOLD  = 2'b10;
    localparam logic [1:0] CTR_REDIR = 2'b01;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                pend_redir_q, pend_redir_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic                miss_start;

    // Next-state and zero-latency fetch control; reset forces a hold with no flush.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        pend_redir_d = pend_redir_q;
        pend_pc_d    = pend_pc_q;
        miss_start   = 1'b0;
        ctr          = CTR_HOLD;
        flush        = 1'b0;
        redirect_pc  = '0;

        if (rst) begin
            case (state_q)
                RUN: begin
                    if (br_taken) begin
                        ctr         = CTR_REDIR;
                        redirect_pc = br_target;
                        flush       = 1'b1;
                    end else if (ic_miss) begin
                        mem_addr_d = fe_pc & LINE_MASK;
                        mem_req_d  = 1'b1;
                        miss_start = 1'b1;
                        state_d    = REQ;
                    end else if (!id_stall) begin
                        ctr = CTR_ADV;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = WAIT;
                    end
                    if (br_taken) begin
                        pend_redir_d = 1'b1;
                        pend_pc_d    = br_target;
                        flush        = 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state_d      = RUN;
                        pend_redir_d = 1'b0;
                        // A branch arriving with mem_done is newer than any pending one.
                        if (br_taken) begin
                            ctr         = CTR_REDIR;
                            redirect_pc = br_target;
                            flush       = 1'b1;
                        end else if (pend_redir_q) begin
                            ctr         = CTR_REDIR;
                            redirect_pc = pend_pc_q;
                            flush       = 1'b1;
                        end
                    end else if (br_taken) begin
                        pend_redir_d = 1'b1;
                        pend_pc_d    = br_target;
                        flush        = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, refill request and saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            pend_redir_q <= 1'b0;
            pend_pc_q    <= '0;
            stall_cnt    <= '0;
            miss_cnt     <= '0;
        end else begin
            state_q      <= state_d;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
            pend_redir_q <= pend_redir_d;
            pend_pc_q    <= pend_pc_d;
            if (ctr == CTR_HOLD && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (miss_start && miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    // Refill completion is only legal while waiting for it.
    a_mem_done_in_wait: assert property (@(posedge clk) disable iff (!rst)
        mem_done |-> state_q == WAIT);

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed bench for fe_fetch_ctrl with 4-bit counters so saturation is reachable.
module tb_fe_fetch_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] fe_pc;
    logic              ic_miss;
    logic              id_stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_done;
    logic [1:0]        ctr;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int errors = 0;
    int checks = 0;

    fe_fetch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fe_pc(fe_pc), .ic_miss(ic_miss), .id_stall(id_stall),
        .br_taken(br_taken), .br_target(br_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_done(mem_done), .ctr(ctr), .redirect_pc(redirect_pc),
        .flush(flush), .stall_cnt(stall_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ic_miss = 1'b0; id_stall = 1'b0; br_taken = 1'b0;
        br_target = '0; mem_ack = 1'b0; mem_done = 1'b0;
    endtask

    // Advance one cycle; inputs are driven and outputs sampled mid-low-phase.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; fe_pc = '0; idle_inputs();
        #1;
        checks++; if (ctr !== 2'b10) begin errors++; $display("FAIL reset_ctr: got %b expected 10", ctr); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (stall_cnt !== 4'd0 || miss_cnt !== 4'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, miss_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_run();
        logic [ADDR_W-1:0] exp_pc;
        apply_reset();
        fe_pc = '0;
        for (int i = 0; i < 5; i++) begin
            exp_pc = ADDR_W'(i * 4);
            checks++; if (ctr !== 2'b00) begin errors++; $display("FAIL run_ctr[%0d]: got %b expected 00", i, ctr); end
            checks++; if (fe_pc !== exp_pc) begin errors++; $display("FAIL run_pc[%0d]: got %h expected %h", i, fe_pc, exp_pc); end
            if (ctr == 2'b00) fe_pc = fe_pc + 32'd4;
            tick();
        end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL run_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_miss();
        int req_cycles = 0;
        int hold_cycles = 0;
        apply_reset();
        fe_pc = 32'h24;
        for (int c = 0; c < 6; c++) begin
            ic_miss  = (c == 0);
            mem_ack  = (c == 2);
            mem_done = (c == 5);
            #1;
            if (mem_req) req_cycles++;
            if (ctr == 2'b10) hold_cycles++;
            if (c == 1) begin
                checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL miss_mem_addr: got %h expected 20", mem_addr); end
            end
            if (c == 3) begin
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop: got %b expected 0", mem_req); end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (ctr !== 2'b00) begin errors++; $display("FAIL miss_resume_ctr: got %b expected 00", ctr); end
        checks++; if (req_cycles != 2) begin errors++; $display("FAIL miss_req_cycles: got %0d expected 2", req_cycles); end
        checks++; if (hold_cycles != 6) begin errors++; $display("FAIL miss_hold_cycles: got %0d expected 6", hold_cycles); end
        checks++; if (miss_cnt !== 4'd1) begin errors++; $display("FAIL miss_miss_cnt: got %0d expected 1", miss_cnt); end
        checks++; if (stall_cnt !== 4'd6) begin errors++; $display("FAIL miss_stall_cnt: got %0d expected 6", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        fe_pc = 32'h80;
        br_taken = 1'b1; br_target = 32'h100; ic_miss = 1'b1; id_stall = 1'b1;
        #1;
        checks++; if (ctr !== 2'b01) begin errors++; $display("FAIL prio_ctr: got %b expected 01", ctr); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL prio_redirect_pc: got %h expected 100", redirect_pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush: got %b expected 1", flush); end
        tick();
        idle_inputs();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL prio_mem_req: got %b expected 0", mem_req); end
        checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL prio_miss_cnt: got %0d expected 0", miss_cnt); end
        checks++; if (ctr !== 2'b00) begin errors++; $display("FAIL prio_after_ctr: got %b expected 00", ctr); end
    endtask

    task automatic test_pending_redirect();
        apply_reset();
        fe_pc = 32'h40; ic_miss = 1'b1;
        tick();
        ic_miss = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        #1;
        checks++; if (flush !== 1'b1 || ctr !== 2'b10) begin errors++; $display("FAIL pend_br1: got flush=%b ctr=%b expected 1/10", flush, ctr); end
        tick();
        br_target = 32'h300;
        #1;
        checks++; if (flush !== 1'b1 || ctr !== 2'b10) begin errors++; $display("FAIL pend_br2: got flush=%b ctr=%b expected 1/10", flush, ctr); end
        tick();
        br_taken = 1'b0; br_target = '0;
        #1;
        checks++; if (flush !== 1'b0 || ctr !== 2'b10) begin errors++; $display("FAIL pend_quiet: got flush=%b ctr=%b expected 0/10", flush, ctr); end
        tick();
        mem_done = 1'b1;
        #1;
        checks++; if (ctr !== 2'b01) begin errors++; $display("FAIL pend_done_ctr: got %b expected 01", ctr); end
        checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL pend_done_pc: got %h expected 300", redirect_pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pend_done_flush: got %b expected 1", flush); end
        tick();
        mem_done = 1'b0;
        #1;
        checks++; if (ctr !== 2'b00 || flush !== 1'b0) begin errors++; $display("FAIL pend_after: got ctr=%b flush=%b expected 00/0", ctr, flush); end
        checks++; if (miss_cnt !== 4'd1) begin errors++; $display("FAIL pend_miss_cnt: got %0d expected 1", miss_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fe_pc = 32'h58; ic_miss = 1'b1;
        tick();
        ic_miss = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b expected 1", mem_req); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL areset_mem_req: got %b expected 0", mem_req); end
        checks++; if (ctr !== 2'b10) begin errors++; $display("FAIL areset_ctr: got %b expected 10", ctr); end
        checks++; if (stall_cnt !== 4'd0 || miss_cnt !== 4'd0) begin errors++; $display("FAIL areset_counters: got %0d/%0d expected 0/0", stall_cnt, miss_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ctr !== 2'b00 || mem_req !== 1'b0) begin errors++; $display("FAIL areset_release: got ctr=%b req=%b expected 00/0", ctr, mem_req); end
    endtask

    task automatic test_saturation();
        apply_reset();
        id_stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                checks++; if (stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid: got %0d expected 10", stall_cnt); end
            end
            if (i == 15) begin
                checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", stall_cnt); end
            end
        end
        checks++; if (ctr !== 2'b10 || flush !== 1'b0) begin errors++; $display("FAIL sat_hold: got ctr=%b flush=%b expected 10/0", ctr, flush); end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", stall_cnt); end
        id_stall = 1'b0;
        #1;
        checks++; if (ctr !== 2'b00) begin errors++; $display("FAIL sat_release_ctr: got %b expected 00", ctr); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_miss();
        test_branch_priority();
        test_pending_redirect();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
